// File: rtl/key_demux_if.sv
// Stream bundle for key_demux: keyed input handshake plus per-channel output
// handshakes and occupancy. The producer/consumer side uses master, the block uses slave.
interface key_demux_if #(
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 2,
   parameter int DEPTH    = 2
);
   localparam int NR_OUT = 2 ** KEY_LEN;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic                       in_valid;
   logic                       in_ready;
   logic [KEY_LEN-1:0]         in_key;
   logic [DATA_LEN-1:0]        in_data;
   logic [NR_OUT-1:0]          out_valid;
   logic [NR_OUT-1:0]          out_ready;
   logic [NR_OUT*DATA_LEN-1:0] out_data;
   logic [NR_OUT*CW-1:0]       occ;

   modport master (
      output in_valid, in_key, in_data, out_ready,
      input  in_ready, out_valid, out_data, occ
   );

   modport slave (
      input  in_valid, in_key, in_data, out_ready,
      output in_ready, out_valid, out_data, occ
   );
endinterface

// File: rtl/key_demux.sv
// Keyed 1-to-N demultiplexer: each input word is steered by its key into one of
// 2**KEY_LEN independent FIFOs, each draining through its own valid/ready handshake.
module key_demux #(
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 2,
   parameter int DEPTH    = 2
) (
   input  logic       clk,
   input  logic       rst,
   key_demux_if.slave bus
);
   localparam int NR_OUT = 2 ** KEY_LEN;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = PW + 1;

   logic [DATA_LEN-1:0] mem_q [NR_OUT][DEPTH];
   logic [DATA_LEN-1:0] mem_d [NR_OUT][DEPTH];
   logic [PW-1:0]       rp_q  [NR_OUT];
   logic [PW-1:0]       rp_d  [NR_OUT];
   logic [PW-1:0]       wp_q  [NR_OUT];
   logic [PW-1:0]       wp_d  [NR_OUT];
   logic [CW-1:0]       cnt_q [NR_OUT];
   logic [CW-1:0]       cnt_d [NR_OUT];

   logic [NR_OUT-1:0]          full_s;
   logic [NR_OUT-1:0]          empty_s;
   logic [NR_OUT-1:0]          push_s;
   logic [NR_OUT-1:0]          pop_s;
   logic                       in_ready_s;
   logic [NR_OUT-1:0]          out_valid_s;
   logic [NR_OUT*DATA_LEN-1:0] out_data_s;
   logic [NR_OUT*CW-1:0]       occ_s;

   // Flag decode and handshakes; a full channel still accepts when it pops this cycle.
   always_comb begin
      full_s     = '0;
      empty_s    = '0;
      push_s     = '0;
      pop_s      = '0;
      in_ready_s = 1'b0;
      for (int i = 0; i < NR_OUT; i++) begin
         full_s[i]  = (cnt_q[i] == CW'(DEPTH));
         empty_s[i] = (cnt_q[i] == CW'(0));
      end
      in_ready_s = !full_s[bus.in_key] || bus.out_ready[bus.in_key];
      for (int i = 0; i < NR_OUT; i++) begin
         push_s[i] = bus.in_valid && in_ready_s && (bus.in_key == KEY_LEN'(i));
         pop_s[i]  = !empty_s[i] && bus.out_ready[i];
      end
   end

   // Per-channel pointer, count and storage next state.
   always_comb begin
      mem_d = mem_q;
      rp_d  = rp_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NR_OUT; i++) begin
         if (push_s[i]) begin
            mem_d[i][wp_q[i]] = bus.in_data;
            wp_d[i]           = wp_q[i] + PW'(1);
         end else begin
            wp_d[i] = wp_q[i];
         end
         if (pop_s[i]) begin
            rp_d[i] = rp_q[i] + PW'(1);
         end else begin
            rp_d[i] = rp_q[i];
         end
         case ({push_s[i], pop_s[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // Head word, valid and occupancy packed per channel.
   always_comb begin
      out_valid_s = '0;
      out_data_s  = '0;
      occ_s       = '0;
      for (int i = 0; i < NR_OUT; i++) begin
         out_valid_s[i]                     = !empty_s[i];
         out_data_s[i*DATA_LEN +: DATA_LEN] = mem_q[i][rp_q[i]];
         occ_s[i*CW +: CW]                  = cnt_q[i];
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = out_data_s;
   assign bus.occ       = occ_s;

   // State register; reset discards every buffered word and same-cycle traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR_OUT; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
            rp_q[i]  <= '0;
            wp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
         rp_q  <= rp_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_key_demux.sv
// Bench for key_demux: directed vector table, hand-written corner sequences and a
// random run, all checked against per-channel queues kept in the bench.
module tb_key_demux;
   localparam int KL = 2;
   localparam int DL = 2;
   localparam int DEPTH = 2;
   localparam int NR = 4;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_total = 0;

   logic [DL-1:0] q [NR][$];
   logic [DL-1:0] popped1 [$];

   key_demux_if #(.KEY_LEN(KL), .DATA_LEN(DL), .DEPTH(DEPTH)) bus ();

   key_demux #(.KEY_LEN(KL), .DATA_LEN(DL), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         r;
      bit         v;
      logic [1:0] k;
      logic [1:0] d;
      logic [3:0] ordy;
      bit         e_rdy;
      logic [3:0] e_ov;
      logic [7:0] e_occ;
      logic [7:0] e_dat;
      bit         dall;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input bit r, input bit v, input logic [1:0] k, input logic [1:0] d,
                        input logic [3:0] ordy);
      rst           = r;
      bus.in_valid  = v;
      bus.in_key    = k;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
   endtask

   // One cycle checked against the queue model, then the model advances with the edge.
   task automatic cycle(input bit r, input bit v, input logic [1:0] k, input logic [1:0] d,
                        input logic [3:0] ordy);
      bit acc;
      drive(r, v, k, d, ordy);
      acc = (q[k].size() < DEPTH) || ordy[k];
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, acc});
      for (int i = 0; i < NR; i++) begin
         chk($sformatf("out_valid[%0d]", i), {31'd0, bus.out_valid[i]}, {31'd0, q[i].size() > 0});
         chk($sformatf("occ[%0d]", i), {30'd0, bus.occ[i*CW +: CW]}, q[i].size());
         if (q[i].size() > 0)
            chk($sformatf("out_data[%0d]", i), {30'd0, bus.out_data[i*DL +: DL]}, {30'd0, q[i][0]});
      end
      if (!r && bus.out_valid[1] && ordy[1]) popped1.push_back(bus.out_data[3:2]);
      if (r) begin
         for (int i = 0; i < NR; i++) q[i].delete();
      end else begin
         for (int i = 0; i < NR; i++)
            if (q[i].size() > 0 && ordy[i]) void'(q[i].pop_front());
         if (v && acc) q[k].push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] mask;
      int         sent;
      logic [1:0] w;
      bit         acc;
      logic [3:0] ordy;

      //            r  v  k  d  ordy     rdy ov       occ    dat    dall
      tbl[0]  = '{1'b1, 1'b1, 2'd2, 2'd3, 4'b0000, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 2'd1, 2'd2, 4'b0000, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 2'd0, 2'd3, 4'b1111, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 2'd1, 2'd2, 4'b1111, 1'b1, 4'b0001, 8'h01, 8'h03, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 2'd2, 2'd1, 4'b1111, 1'b1, 4'b0010, 8'h04, 8'h08, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 2'd3, 2'd0, 4'b1111, 1'b1, 4'b0100, 8'h10, 8'h10, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 1'b1, 4'b1000, 8'h40, 8'h00, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 2'd2, 2'd1, 4'b1011, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 2'd2, 2'd2, 4'b1011, 1'b1, 4'b0100, 8'h10, 8'h10, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 2'd2, 2'd3, 4'b1011, 1'b0, 4'b0100, 8'h20, 8'h10, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 2'd2, 2'd3, 4'b1111, 1'b1, 4'b0100, 8'h20, 8'h10, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 2'd2, 2'd0, 4'b1111, 1'b1, 4'b0100, 8'h20, 8'h20, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 2'd2, 2'd0, 4'b1111, 1'b1, 4'b0100, 8'h10, 8'h30, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 2'd2, 2'd0, 4'b1111, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0};

      drive(1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
      @(posedge clk);
      #1;

      for (int t = 0; t < 16; t++) begin
         drive(tbl[t].r, tbl[t].v, tbl[t].k, tbl[t].d, tbl[t].ordy);
         mask = {{2{tbl[t].e_ov[3]}}, {2{tbl[t].e_ov[2]}}, {2{tbl[t].e_ov[1]}},
                 {2{tbl[t].e_ov[0]}}} | {8{tbl[t].dall}};
         chk($sformatf("tbl%0d in_ready", t), {31'd0, bus.in_ready}, {31'd0, tbl[t].e_rdy});
         chk($sformatf("tbl%0d out_valid", t), {28'd0, bus.out_valid}, {28'd0, tbl[t].e_ov});
         chk($sformatf("tbl%0d occ", t), {24'd0, bus.occ}, {24'd0, tbl[t].e_occ});
         chk($sformatf("tbl%0d out_data", t), {24'd0, bus.out_data & mask},
             {24'd0, tbl[t].e_dat & mask});
         @(posedge clk);
         #1;
      end

      // Wrap-around on channel 1 with its consumer toggling every cycle.
      for (int i = 0; i < NR; i++) q[i].delete();
      popped1.delete();
      sent = 0;
      for (int c = 0; c < 40 && sent < 10; c++) begin
         ordy = (c % 2 == 0) ? 4'b0010 : 4'b0000;
         acc  = (q[1].size() < DEPTH) || ordy[1];
         w    = 2'((sent * 3) % 4);
         cycle(1'b0, 1'b1, 2'd1, w, ordy);
         if (acc) sent++;
      end
      for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 2'd1, 2'd0, 4'b0010);
      chk("wrap sent", sent, 10);
      chk("wrap popped count", popped1.size(), 10);
      for (int j = 0; j < popped1.size() && j < 10; j++)
         chk($sformatf("wrap order %0d", j), {30'd0, popped1[j]}, (j * 3) % 4);

      // Independent drains of channels 0 and 3 in the same cycle.
      cycle(1'b0, 1'b1, 2'd0, 2'd1, 4'b0000);
      cycle(1'b0, 1'b1, 2'd0, 2'd2, 4'b0000);
      cycle(1'b0, 1'b1, 2'd3, 2'd3, 4'b0000);
      cycle(1'b0, 1'b1, 2'd3, 2'd0, 4'b0000);
      cycle(1'b0, 1'b0, 2'd0, 2'd0, 4'b1001);
      chk("drain occ", {24'd0, bus.occ}, 32'h41);

      // Mid-operation reset during an accepted push to key 3.
      cycle(1'b0, 1'b1, 2'd0, 2'd3, 4'b0000);
      chk("pre-reset occ", {24'd0, bus.occ}, 32'h42);
      cycle(1'b1, 1'b1, 2'd3, 2'd2, 4'b0000);
      chk("post-reset occ", {24'd0, bus.occ}, 32'h0);
      chk("post-reset out_valid", {28'd0, bus.out_valid}, 32'h0);
      for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 2'd3, 2'd0, 4'b1111);

      // Random traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
